// File: rtl/wb_trace_pkg.sv
// wb_trace_pkg: shared constants, trace record type, serializer states and frame builder
package wb_trace_pkg;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
    localparam int FRAME_BYTES = 8;
    localparam int STAMP_W = 16;
    typedef struct packed {
        logic [STAMP_W-1:0] stamp;
        logic [4:0]         rd;
        logic [31:0]        data;
    } trace_rec_t;
    typedef enum logic { IDLE, SEND } ser_state_t;
    // Whole frame as one word, byte 0 in the top byte
    function automatic logic [8*FRAME_BYTES-1:0] frame_bytes(input trace_rec_t r, input logic [7:0] sync);
        return {sync, r.stamp, 3'b000, r.rd, r.data};
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO of trace records
//   i_clk/i_rst_n : clock, async active-low reset
//   i_push/i_din  : write a record (caller guarantees room, or a pop on the same edge)
//   i_pop/o_dout  : drop the head record; o_dout shows the head while not empty
//   o_full/o_empty/o_level : occupancy status
module trace_fifo import wb_trace_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  trace_rec_t               i_din,
    output trace_rec_t               o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    trace_rec_t r_mem [DEPTH];
    logic [AW:0] r_wr, r_rd;
    assign o_level = r_wr - r_rd;
    assign o_empty = r_wr == r_rd;
    // Level never exceeds DEPTH, so its top bit alone marks full
    assign o_full  = o_level[AW];
    assign o_dout  = r_mem[r_rd[AW-1:0]];
    always_ff @(posedge i_clk)
        if (i_push) r_mem[r_wr[AW-1:0]] <= i_din;
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
        end
endmodule

// File: rtl/wb_trace_streamer.sv
// wb_trace_streamer: timestamps WB register writes and streams them as 8-byte frames
//   clk/resetManual   : clock, async active-low reset
//   trace_en, PIPE_MEMWB_* , memtoRegOutput : write-back observation
//   tx_data/tx_valid/tx_ready : byte stream (SYNC, stamp hi/lo, reg, data MSB..LSB)
//   overflow/drop_count/clr_overflow : dropped-event accounting
//   fifo_level        : queued records not yet started
module wb_trace_streamer import wb_trace_pkg::*; #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE
) (
    input  logic                   clk,
    input  logic                   resetManual,
    input  logic                   trace_en,
    input  logic                   PIPE_MEMWB_OUT_CSignal_RegWrite,
    input  logic [4:0]             PIPE_MEMWB_RegDstOutput,
    input  logic [31:0]            memtoRegOutput,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   overflow,
    output logic [7:0]             drop_count,
    input  logic                   clr_overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);
    logic [STAMP_W-1:0] r_stamp;
    ser_state_t         r_state;
    trace_rec_t         r_frame;
    logic [2:0]         r_idx;
    trace_rec_t         w_head, w_rec;
    logic               w_cap, w_full, w_empty, w_pop, w_push, w_drop, w_hs, w_last;
    logic [2:0]         w_nidx;
    logic [63:0]        w_shift;

    assign w_cap   = PIPE_MEMWB_OUT_CSignal_RegWrite && trace_en && (PIPE_MEMWB_RegDstOutput != 5'd0);
    assign w_hs    = tx_valid && tx_ready;
    assign w_last  = w_hs && (r_idx == 3'd7);
    assign w_pop   = !w_empty && (r_state == IDLE || w_last);
    // A full FIFO still takes a record when the head leaves on the same edge
    assign w_push  = w_cap && (!w_full || w_pop);
    assign w_drop  = w_cap && !w_push;
    assign w_rec   = '{stamp: r_stamp, rd: PIPE_MEMWB_RegDstOutput, data: memtoRegOutput};
    assign w_nidx  = r_idx + 3'd1;
    assign w_shift = frame_bytes(r_frame, SYNC_BYTE) << {w_nidx, 3'b000};

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (clk),
        .i_rst_n (resetManual),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (w_rec),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge clk or negedge resetManual)
        if (!resetManual) begin
            r_stamp    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            r_stamp <= r_stamp + 1'b1;
            if (w_drop) begin
                overflow   <= 1'b1;
                drop_count <= clr_overflow ? 8'd1 : drop_count + {7'd0, drop_count != 8'hFF};
            end else if (clr_overflow) begin
                overflow   <= 1'b0;
                drop_count <= '0;
            end
        end

    always_ff @(posedge clk or negedge resetManual)
        if (!resetManual) begin
            r_state  <= IDLE;
            r_frame  <= '0;
            r_idx    <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else if (w_pop) begin
            r_state  <= SEND;
            r_frame  <= w_head;
            r_idx    <= '0;
            tx_valid <= 1'b1;
            tx_data  <= SYNC_BYTE;
        end else if (r_state == SEND && w_hs) begin
            if (w_last) begin
                r_state  <= IDLE;
                tx_valid <= 1'b0;
                tx_data  <= '0;
            end else begin
                r_idx   <= w_nidx;
                tx_data <= w_shift[63:56];
            end
        end
endmodule

// File: tb/tb_wb_trace_streamer.sv
// tb_wb_trace_streamer: vector table, corner sequences and random traffic against a queue model
module tb_wb_trace_streamer;
    localparam int DEPTH = 8;
    localparam int LW = $clog2(DEPTH) + 1;

    logic clk = 0, resetManual = 1, trace_en = 1, we = 0, tx_ready = 0, clr_overflow = 0;
    logic [4:0] rd = 0;
    logic [31:0] dat = 0;
    logic [7:0] tx_data, drop_count;
    logic tx_valid, overflow;
    logic [LW-1:0] fifo_level;
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    wb_trace_streamer #(.DEPTH(DEPTH), .SYNC_BYTE(8'hA5)) dut (
        .clk                             (clk),
        .resetManual                     (resetManual),
        .trace_en                        (trace_en),
        .PIPE_MEMWB_OUT_CSignal_RegWrite (we),
        .PIPE_MEMWB_RegDstOutput         (rd),
        .memtoRegOutput                  (dat),
        .tx_data                         (tx_data),
        .tx_valid                        (tx_valid),
        .tx_ready                        (tx_ready),
        .overflow                        (overflow),
        .drop_count                      (drop_count),
        .clr_overflow                    (clr_overflow),
        .fifo_level                      (fifo_level)
    );

    typedef struct { logic [15:0] st; logic [4:0] rd; logic [31:0] d; } mrec_t;
    typedef struct { logic we; logic [4:0] rd; logic [31:0] d; logic rdy; logic ev; logic [7:0] ed; logic [3:0] el; } vec_t;

    mrec_t fq[$];
    logic [7:0] cur[$];
    logic [7:0] rx[$];
    logic [15:0] m_stamp;
    logic m_ovf;
    logic [7:0] m_drop;
    logic p_valid, p_ready;
    logic [7:0] p_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        cur.delete();
        m_stamp = 0;
        m_ovf = 0;
        m_drop = 0;
        p_valid = 0;
        p_ready = 0;
        p_data = 0;
    endtask

    // One clock: advance the model from the pre-edge inputs, then compare after the edge
    task automatic tick();
        bit sending, hs, last, pop, cap, push;
        mrec_t r;
        logic [63:0] f;
        sending = cur.size() > 0;
        hs = sending && tx_ready;
        last = hs && cur.size() == 1;
        pop = fq.size() > 0 && (!sending || last);
        cap = we && trace_en && rd != 5'd0;
        push = cap && (fq.size() < DEPTH || pop);
        if (tx_valid && tx_ready) rx.push_back(tx_data);
        p_valid = tx_valid;
        p_ready = tx_ready;
        p_data = tx_data;
        if (hs) void'(cur.pop_front());
        if (pop) begin
            r = fq.pop_front();
            f = {8'hA5, r.st, 3'b000, r.rd, r.d};
            cur.delete();
            for (int i = 0; i < 8; i++) cur.push_back(f[63-8*i -: 8]);
        end
        if (push) fq.push_back('{m_stamp, rd, dat});
        if (cap && !push) begin
            m_ovf = 1;
            m_drop = clr_overflow ? 8'd1 : (m_drop == 8'hFF ? 8'hFF : m_drop + 8'd1);
        end else if (clr_overflow) begin
            m_ovf = 0;
            m_drop = 0;
        end
        m_stamp++;
        @(posedge clk);
        #1;
        chk("tx_valid", {31'd0, tx_valid}, {31'd0, cur.size() > 0});
        if (cur.size() > 0) chk("tx_data", {24'd0, tx_data}, {24'd0, cur[0]});
        chk("fifo_level", {28'd0, fifo_level}, fq.size());
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        chk("drop_count", {24'd0, drop_count}, {24'd0, m_drop});
        if (p_valid && !p_ready) begin
            chk("hold_valid", {31'd0, tx_valid}, 1);
            chk("hold_data", {24'd0, tx_data}, {24'd0, p_data});
        end
    endtask

    task automatic do_reset();
        resetManual = 0;
        #1;
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        chk("rst_overflow", {31'd0, overflow}, 0);
        chk("rst_drop_count", {24'd0, drop_count}, 0);
        chk("rst_fifo_level", {28'd0, fifo_level}, 0);
        model_reset();
        @(posedge clk);
        #1;
        resetManual = 1;
    endtask

    vec_t tv[14];
    logic [7:0] eb[8];
    logic [15:0] st0, sb;
    logic [63:0] ef;

    initial begin
        #2;
        do_reset();

        eb = '{8'hA5, 8'h00, 8'h03, 8'h05, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        for (int i = 0; i < 14; i++) tv[i] = '{1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 8'd0, 4'd0};
        tv[3].we = 1; tv[3].rd = 5'd5; tv[3].d = 32'hDEADBEEF; tv[3].el = 4'd1;
        for (int i = 4; i < 12; i++) begin tv[i].ev = 1; tv[i].ed = eb[i-4]; end
        trace_en = 1;
        for (int i = 0; i < 14; i++) begin
            we = tv[i].we; rd = tv[i].rd; dat = tv[i].d; tx_ready = tv[i].rdy;
            tick();
            chk("vec_valid", {31'd0, tx_valid}, {31'd0, tv[i].ev});
            if (tv[i].ev) chk("vec_data", {24'd0, tx_data}, {24'd0, tv[i].ed});
            chk("vec_level", {28'd0, fifo_level}, {28'd0, tv[i].el});
        end
        we = 0;

        // Writes to r0 and writes with capture disabled leave no trace
        we = 1; rd = 0; dat = 32'h11111111;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("r0_level", {28'd0, fifo_level}, 0);
            chk("r0_valid", {31'd0, tx_valid}, 0);
        end
        rd = 7; trace_en = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("dis_level", {28'd0, fifo_level}, 0);
            chk("dis_valid", {31'd0, tx_valid}, 0);
        end
        we = 0; trace_en = 1;

        // Back-pressure 1,0,0,1,... keeps frame content intact
        rx.delete();
        we = 1; rd = 9; dat = 32'h12345678; tx_ready = 1;
        st0 = m_stamp;
        tick();
        we = 0;
        for (int c = 0; c < 80 && rx.size() < 8; c++) begin
            tx_ready = (c % 3 == 0);
            tick();
        end
        chk("bp_len", rx.size(), 8);
        ef = {8'hA5, st0, 3'b000, 5'd9, 32'h12345678};
        if (rx.size() >= 8)
            for (int i = 0; i < 8; i++) chk("bp_byte", {24'd0, rx[i]}, {24'd0, ef[63-8*i -: 8]});
        tx_ready = 1;
        for (int i = 0; i < 3; i++) tick();

        // Burst into a stalled streamer: fill, drop, clear, saturate, then drain back-to-back
        tx_ready = 0;
        we = 1; rd = 1; dat = 32'hA0A0A0A0;
        tick();
        we = 0;
        tick();
        chk("burst_start_valid", {31'd0, tx_valid}, 1);
        sb = m_stamp;
        for (int k = 0; k < DEPTH + 3; k++) begin
            we = 1; rd = 5'(k % 31 + 1); dat = $urandom;
            tick();
        end
        chk("burst_level", {28'd0, fifo_level}, DEPTH);
        chk("burst_drop", {24'd0, drop_count}, 3);
        chk("burst_ovf", {31'd0, overflow}, 1);
        clr_overflow = 1;
        tick();
        clr_overflow = 0;
        chk("clr_drop_same_edge_cnt", {24'd0, drop_count}, 1);
        chk("clr_drop_same_edge_ovf", {31'd0, overflow}, 1);
        for (int k = 0; k < 300; k++) tick();
        chk("drop_saturate", {24'd0, drop_count}, 255);
        we = 0; clr_overflow = 1;
        tick();
        clr_overflow = 0;
        chk("clr_drop", {24'd0, drop_count}, 0);
        chk("clr_ovf", {31'd0, overflow}, 0);
        chk("clr_level_kept", {28'd0, fifo_level}, DEPTH);
        rx.delete();
        tx_ready = 1;
        for (int i = 0; i < 8 * (DEPTH + 1); i++) tick();
        chk("drain_bytes", rx.size(), 8 * (DEPTH + 1));
        tick();
        chk("drain_idle", {31'd0, tx_valid}, 0);
        if (rx.size() >= 8 * (DEPTH + 1))
            for (int f = 1; f <= DEPTH; f++) begin
                chk("drain_sync", {24'd0, rx[8*f]}, 32'hA5);
                chk("drain_stamp", {16'd0, rx[8*f+1], rx[8*f+2]}, {16'd0, sb + 16'(f - 1)});
            end

        // Reset while byte 3 is on the wire
        we = 1; rd = 3; dat = $urandom; tx_ready = 1;
        tick();
        we = 0;
        rx.delete();
        for (int c = 0; c < 20 && rx.size() < 3; c++) tick();
        chk("pre_rst_byte3", {24'd0, tx_data}, 32'h03);
        do_reset();
        we = 1; rd = 6; dat = 32'hCAFEF00D;
        tick();
        we = 0;
        rx.delete();
        for (int c = 0; c < 20 && rx.size() < 8; c++) tick();
        chk("post_rst_len", rx.size(), 8);
        if (rx.size() >= 8) begin
            chk("post_rst_b0", {24'd0, rx[0]}, 32'hA5);
            chk("post_rst_b1", {24'd0, rx[1]}, 0);
            chk("post_rst_b2", {24'd0, rx[2]}, 0);
            chk("post_rst_b3", {24'd0, rx[3]}, 6);
            chk("post_rst_b7", {24'd0, rx[7]}, 32'h0D);
        end

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            we = $urandom_range(0, 1);
            rd = 5'($urandom_range(0, 31));
            dat = $urandom;
            trace_en = $urandom_range(0, 9) != 0;
            tx_ready = $urandom_range(0, 9) < 6;
            clr_overflow = $urandom_range(0, 49) == 0;
            tick();
        end
        we = 0; clr_overflow = 0; tx_ready = 1; trace_en = 1;
        for (int c = 0; c < 100; c++) tick();
        chk("final_level", {28'd0, fifo_level}, 0);
        chk("final_idle", {31'd0, tx_valid}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
